// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file.
// Default geometry, address-width helper and write-port identifiers.
package regfile_mp_pkg;

  localparam int RF_DATA_W = 64;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;

  // A single-entry address field is never narrower than one bit.
  function automatic int rf_addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  typedef enum logic {
    WP_ALU  = 1'b0,
    WP_LOAD = 1'b1
  } wr_port_e;

endpackage

// File: rtl/regfile_mp_rdport.sv
// One combinational read port: address mux, zero-register masking and,
// when REGFILE_MP_BYPASS_EN is defined, same-cycle write forwarding.
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = rf_addr_w(RF_DEPTH),
  parameter int HAS_ZERO = 1,
  parameter int ZERO_REG = RF_DEPTH - 1
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] regs_i [DEPTH],
  input  logic [DEPTH-1:0]  busy_i,
  input  logic              wr0_en_i,
  input  logic [ADDR_W-1:0] wr0_addr_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [ADDR_W-1:0] wr1_addr_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  input  logic              busy_set_en_i,
  input  logic [ADDR_W-1:0] busy_set_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_busy_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic              is_zero;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_busy;

  assign is_zero = (HAS_ZERO != 0) && (rd_addr_i == ZERO_ADDR);

`ifdef REGFILE_MP_BYPASS_EN
  logic hit0;
  logic hit1;

  assign hit0 = wr0_en_i && (wr0_addr_i == rd_addr_i);
  assign hit1 = wr1_en_i && (wr1_addr_i == rd_addr_i);

  // A forwarded value is the newest producer, so it is only pending if
  // decode marks the same register again in this very cycle.
  assign fwd_hit  = hit0 || hit1;
  assign fwd_data = hit1 ? wr1_data_i : wr0_data_i;
  assign fwd_busy = busy_set_en_i && (busy_set_addr_i == rd_addr_i);
`else
  logic unused_fwd;

  assign unused_fwd = ^{wr0_en_i, wr0_addr_i, wr0_data_i, wr1_en_i, wr1_addr_i,
                        wr1_data_i, busy_set_en_i, busy_set_addr_i};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
  assign fwd_busy   = 1'b0;
`endif

  // NOTE: combinational blocks assign a default first so no path leaves an
  // output unassigned and infers a latch.
  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    rd_busy_o = busy_i[rd_addr_i];
    if (fwd_hit) begin
      rd_data_o = fwd_data;
      rd_busy_o = fwd_busy;
    end
    if (is_zero) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, pending-bit scoreboard,
// optional hardwired-zero register and debug tap; REGFILE_MP_BYPASS_EN adds read forwarding.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NUM_RD   = RF_NUM_RD,
  parameter  int ZERO_REG = DEPTH - 1,
  parameter  int HAS_ZERO = 1,
  parameter  int DBG_W    = 16,
  localparam int ADDR_W   = rf_addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     busy_set_en,
  input  logic [ADDR_W-1:0]        busy_set_addr,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DBG_W-1:0]         dbg_data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic              wr_en   [2];
  logic [ADDR_W-1:0] wr_addr [2];
  logic [DATA_W-1:0] wr_data [2];

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (HAS_ZERO != 0) && (addr == ZERO_ADDR);
  endfunction

  assign wr_en[WP_ALU]    = wr0_en;
  assign wr_addr[WP_ALU]  = wr0_addr;
  assign wr_data[WP_ALU]  = wr0_data;
  assign wr_en[WP_LOAD]   = wr1_en;
  assign wr_addr[WP_LOAD] = wr1_addr;
  assign wr_data[WP_LOAD] = wr1_data;

  // Ports are applied ALU first, load last, so a same-address conflict
  // leaves the load data; the busy set is applied after the clears so a
  // new producer issued this cycle supersedes the retiring one.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p] && !is_zero(wr_addr[p])) begin
        regs_d[wr_addr[p]] = wr_data[p];
        busy_d[wr_addr[p]] = 1'b0;
      end
    end
    if (busy_set_en && !is_zero(busy_set_addr)) begin
      busy_d[busy_set_addr] = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments, and the storage array is
  // reset as a whole because reads must return 0 while reset is held; this
  // keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .HAS_ZERO (HAS_ZERO),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .rd_addr_i       (rd_addr[k*ADDR_W +: ADDR_W]),
      .regs_i          (regs_q),
      .busy_i          (busy_q),
      .wr0_en_i        (wr0_en),
      .wr0_addr_i      (wr0_addr),
      .wr0_data_i      (wr0_data),
      .wr1_en_i        (wr1_en),
      .wr1_addr_i      (wr1_addr),
      .wr1_data_i      (wr1_data),
      .busy_set_en_i   (busy_set_en),
      .busy_set_addr_i (busy_set_addr),
      .rd_data_o       (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy_o       (rd_busy[k])
    );
  end

  // The zero register is never written, so the tap needs no masking.
  assign dbg_data = regs_q[dbg_addr][DBG_W-1:0];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table on the default build plus
// reset, bypass and parametric-sweep sequences.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  // Shared stimulus for the default instance and the no-zero instance.
  logic         w0e, w1e, bse;
  logic [4:0]   w0a, w1a, bsa, dbg_addr;
  logic [63:0]  w0d, w1d;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data_a, rd_data_b;
  logic [1:0]   rd_busy_a, rd_busy_b;
  logic [15:0]  dbg_a, dbg_b;

  // Stimulus for the narrow, three-port instance.
  logic        c_w0e, c_w1e, c_bse;
  logic [3:0]  c_w0a, c_w1a, c_bsa, c_dbg_addr;
  logic [31:0] c_w0d, c_w1d;
  logic [11:0] c_rd_addr;
  logic [95:0] c_rd_data;
  logic [2:0]  c_rd_busy;
  logic [7:0]  c_dbg;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_mp #(.HAS_ZERO(1)) u_dut (
    .clk(clk), .reset(reset),
    .wr0_en(w0e), .wr0_addr(w0a), .wr0_data(w0d),
    .wr1_en(w1e), .wr1_addr(w1a), .wr1_data(w1d),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .busy_set_en(bse), .busy_set_addr(bsa),
    .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  regfile_mp #(.HAS_ZERO(0)) u_dut_nz (
    .clk(clk), .reset(reset),
    .wr0_en(w0e), .wr0_addr(w0a), .wr0_data(w0d),
    .wr1_en(w1e), .wr1_addr(w1a), .wr1_data(w1d),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .busy_set_en(bse), .busy_set_addr(bsa),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  regfile_mp #(.DATA_W(32), .DEPTH(16), .NUM_RD(3), .HAS_ZERO(0), .DBG_W(8)) u_dut_sw (
    .clk(clk), .reset(reset),
    .wr0_en(c_w0e), .wr0_addr(c_w0a), .wr0_data(c_w0d),
    .wr1_en(c_w1e), .wr1_addr(c_w1a), .wr1_data(c_w1d),
    .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .busy_set_en(c_bse), .busy_set_addr(c_bsa),
    .dbg_addr(c_dbg_addr), .dbg_data(c_dbg)
  );

  typedef struct {
    logic        w0e; logic [4:0] w0a; logic [63:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [63:0] w1d;
    logic        bse; logic [4:0] bsa;
    logic [4:0]  ra0; logic [4:0] ra1; logic [4:0] da;
    logic [63:0] e0;  logic [63:0] e1; logic [1:0] eb; logic [15:0] ed;
    logic [63:0] eb0; logic ebb;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    w0e = 1'b0; w1e = 1'b0; bse = 1'b0;
    c_w0e = 1'b0; c_w1e = 1'b0; c_bse = 1'b0;
  endtask

  // Drive one vector across a clock edge, then drop the enables so the
  // checked outputs show stored state only.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    w0e = v.w0e; w0a = v.w0a; w0d = v.w0d;
    w1e = v.w1e; w1a = v.w1a; w1d = v.w1d;
    bse = v.bse; bsa = v.bsa;
    rd_addr = {v.ra1, v.ra0};
    dbg_addr = v.da;
    @(posedge clk);
    #1 idle_inputs();
    #1;
    check($sformatf("v%0d rd0", idx), rd_data_a[63:0], v.e0);
    check($sformatf("v%0d rd1", idx), rd_data_a[127:64], v.e1);
    check($sformatf("v%0d busy", idx), {62'd0, rd_busy_a}, {62'd0, v.eb});
    check($sformatf("v%0d dbg", idx), {48'd0, dbg_a}, {48'd0, v.ed});
    check($sformatf("v%0d nz rd0", idx), rd_data_b[63:0], v.eb0);
    check($sformatf("v%0d nz busy0", idx), {63'd0, rd_busy_b[0]}, {63'd0, v.ebb});
  endtask

  initial begin
    //           w0e  w0a    w0d                    w1e  w1a    w1d                    bse  bsa    ra0    ra1    da     e0                     e1                     eb     ed          eb0                    ebb
    vecs[0]  = '{1'b0, 5'd0,  64'h0,                 1'b0, 5'd0,  64'h0,                 1'b0, 5'd0,  5'd0,  5'd1,  5'd0,  64'h0,                 64'h0,                 2'b00, 16'h0,      64'h0,                 1'b0};
    vecs[1]  = '{1'b1, 5'd3,  64'h1111,              1'b1, 5'd3,  64'h2222,              1'b0, 5'd0,  5'd3,  5'd0,  5'd3,  64'h2222,              64'h0,                 2'b00, 16'h2222,   64'h2222,              1'b0};
    vecs[2]  = '{1'b1, 5'd4,  64'h0123456789ABCDEF,  1'b1, 5'd9,  64'hFEDCBA9876543210,  1'b0, 5'd0,  5'd4,  5'd9,  5'd4,  64'h0123456789ABCDEF,  64'hFEDCBA9876543210,  2'b00, 16'hCDEF,   64'h0123456789ABCDEF,  1'b0};
    vecs[3]  = '{1'b1, 5'd31, 64'hFFFF,              1'b0, 5'd0,  64'h0,                 1'b0, 5'd0,  5'd31, 5'd3,  5'd31, 64'h0,                 64'h2222,              2'b00, 16'h0,      64'hFFFF,              1'b0};
    vecs[4]  = '{1'b0, 5'd0,  64'h0,                 1'b0, 5'd0,  64'h0,                 1'b1, 5'd31, 5'd31, 5'd4,  5'd9,  64'h0,                 64'h0123456789ABCDEF,  2'b00, 16'h3210,   64'hFFFF,              1'b1};
    vecs[5]  = '{1'b0, 5'd0,  64'h0,                 1'b0, 5'd0,  64'h0,                 1'b1, 5'd7,  5'd7,  5'd3,  5'd7,  64'h0,                 64'h2222,              2'b01, 16'h0,      64'h0,                 1'b1};
    vecs[6]  = '{1'b1, 5'd7,  64'h77,                1'b0, 5'd0,  64'h0,                 1'b1, 5'd7,  5'd7,  5'd31, 5'd7,  64'h77,                64'h0,                 2'b01, 16'h0077,   64'h77,                1'b1};
    vecs[7]  = '{1'b0, 5'd0,  64'h0,                 1'b1, 5'd7,  64'h78,                1'b0, 5'd0,  5'd7,  5'd9,  5'd3,  64'h78,                64'hFEDCBA9876543210,  2'b00, 16'h2222,   64'h78,                1'b0};
    vecs[8]  = '{1'b0, 5'd0,  64'h0,                 1'b0, 5'd0,  64'h0,                 1'b1, 5'd12, 5'd12, 5'd7,  5'd12, 64'h0,                 64'h78,                2'b01, 16'h0,      64'h0,                 1'b1};
    vecs[9]  = '{1'b1, 5'd13, 64'h13,                1'b0, 5'd0,  64'h0,                 1'b1, 5'd12, 5'd12, 5'd13, 5'd13, 64'h0,                 64'h13,                2'b01, 16'h0013,   64'h0,                 1'b1};
    vecs[10] = '{1'b1, 5'd30, 64'h30,                1'b1, 5'd0,  64'h8000000000000001,  1'b0, 5'd0,  5'd0,  5'd30, 5'd30, 64'h8000000000000001,  64'h30,                2'b00, 16'h0030,   64'h8000000000000001,  1'b0};
    vecs[11] = '{1'b1, 5'd12, 64'h0,                 1'b1, 5'd12, 64'hC12,               1'b0, 5'd0,  5'd12, 5'd13, 5'd12, 64'hC12,               64'h13,                2'b00, 16'h0C12,   64'hC12,               1'b0};

    idle_inputs();
    w0a = '0; w0d = '0; w1a = '0; w1d = '0; bsa = '0; rd_addr = '0; dbg_addr = '0;
    c_w0a = '0; c_w0d = '0; c_w1a = '0; c_w1d = '0; c_bsa = '0; c_rd_addr = '0; c_dbg_addr = '0;

    // Reset state.
    #2;
    check("reset rd", rd_data_a, 128'd0);
    check("reset busy", {62'd0, rd_busy_a}, 64'd0);
    check("reset sweep rd", c_rd_data[63:0], 64'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

    // Async reset mid-cycle clears a freshly written, pending register.
    @(negedge clk);
    w0e = 1'b1; w0a = 5'd5; w0d = 64'hDEAD_BEEF;
    bse = 1'b1; bsa = 5'd5;
    rd_addr = {5'd3, 5'd5}; dbg_addr = 5'd5;
    @(posedge clk);
    #1 idle_inputs();
    #1;
    check("pre-reset rd5", rd_data_a[63:0], 64'hDEAD_BEEF);
    check("pre-reset busy5", {63'd0, rd_busy_a[0]}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("async reset rd5", rd_data_a[63:0], 64'd0);
    check("async reset busy5", {63'd0, rd_busy_a[0]}, 64'd0);
    check("async reset dbg5", {48'd0, dbg_a}, 64'd0);
    check("async reset rd3", rd_data_a[127:64], 64'd0);

    // A write presented while reset is held is aborted.
    @(negedge clk);
    w0e = 1'b1; w0a = 5'd6; w0d = 64'h6666;
    rd_addr = {5'd6, 5'd6};
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check("aborted write rd6", rd_data_a[63:0], 64'd0);

    // Same-cycle read of a register being written.
    @(negedge clk);
    bse = 1'b1; bsa = 5'd2;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    w0e = 1'b1; w0a = 5'd2; w0d = 64'hABCD;
    w1e = 1'b1; w1a = 5'd31; w1d = 64'hFFFF;
    rd_addr = {5'd31, 5'd2}; dbg_addr = 5'd2;
    #1;
    check("same-cycle rd2", rd_data_a[63:0], BYP ? 64'hABCD : 64'h0);
    check("same-cycle busy2", {63'd0, rd_busy_a[0]}, BYP ? 64'd0 : 64'd1);
    check("same-cycle zero reg", rd_data_a[127:64], 64'd0);
    check("same-cycle dbg2", {48'd0, dbg_a}, 64'd0);
    @(posedge clk);
    #1 idle_inputs();
    #1;
    check("next-cycle rd2", rd_data_a[63:0], 64'hABCD);
    check("next-cycle busy2", {63'd0, rd_busy_a[0]}, 64'd0);

    // Dual write plus busy set on the same register in one cycle.
    @(negedge clk);
    w0e = 1'b1; w0a = 5'd2; w0d = 64'h1111;
    w1e = 1'b1; w1a = 5'd2; w1d = 64'h2222;
    bse = 1'b1; bsa = 5'd2;
    rd_addr = {5'd2, 5'd2};
    #1;
    check("fwd priority rd2", rd_data_a[127:64], BYP ? 64'h2222 : 64'hABCD);
    check("fwd busy rd2", {63'd0, rd_busy_a[1]}, BYP ? 64'd1 : 64'd0);
    @(posedge clk);
    #1 idle_inputs();
    #1;
    check("set wins rd2", rd_data_a[127:64], 64'h2222);
    check("set wins busy2", {63'd0, rd_busy_a[1]}, 64'd1);

    // Narrow three-port build: register i holds i*3.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c_w0e = 1'b1; c_w0a = 4'(2 * i);     c_w0d = 32'(6 * i);
      c_w1e = 1'b1; c_w1a = 4'(2 * i + 1); c_w1d = 32'(6 * i + 3);
      @(posedge clk);
      #1 idle_inputs();
    end
    for (int a = 0; a < 16; a++) begin
      c_rd_addr = {4'((a + 11) % 16), 4'((a + 5) % 16), 4'(a)};
      c_dbg_addr = 4'(a);
      #1;
      check($sformatf("sweep a%0d p0", a), {32'd0, c_rd_data[31:0]}, 64'(a * 3));
      check($sformatf("sweep a%0d p1", a), {32'd0, c_rd_data[63:32]}, 64'(((a + 5) % 16) * 3));
      check($sformatf("sweep a%0d p2", a), {32'd0, c_rd_data[95:64]}, 64'(((a + 11) % 16) * 3));
      check($sformatf("sweep a%0d dbg", a), {56'd0, c_dbg}, 64'((a * 3) % 256));
      check($sformatf("sweep a%0d busy", a), {61'd0, c_rd_busy}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the fixed 32x64 single-write/dual-read register file in the CPU datapath.
- Adds configurable width, depth and read-port count, a second write port for the load/ALU writeback split, and a per-register pending (scoreboard) bit for hazard detection.
- Adds a hardwired-zero register option and a debug tap port.
- Sits between decode (reads, busy-set) and writeback (two write ports).

Parameters:
- DATA_W, 64, register width in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register address width; derived, not overridden.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, DEPTH-1, index of the hardwired-zero register.
- HAS_ZERO, 1, 1 = ZERO_REG reads 0 and ignores writes; 0 = ordinary register.
- DBG_W, 16, width of the debug tap output (at most DATA_W).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- wr0_en  in  1  write port 0 enable (ALU writeback).
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable (load writeback).
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies slice k.
- rd_data  out  NUM_RD*DATA_W  read data; port k occupies slice k.
- rd_busy  out  NUM_RD  pending bit of the register addressed by each read port.
- busy_set_en  in  1  mark a register as pending (instruction issued).
- busy_set_addr  in  ADDR_W  register to mark pending.
- dbg_addr  in  ADDR_W  debug tap select.
- dbg_data  out  DBG_W  low DBG_W bits of the selected register.

Behaviour:
- Reset (asynchronous) clears all registers and all pending bits to 0. Consequently rd_data=0, rd_busy=0 and dbg_data=0 immediately and for as long as reset is held.
- A reset asserted mid-write aborts that write; the register stays 0.
- Writes take effect at the clk rising edge when wrX_en=1.
- If both write ports target the same address in one cycle, port 1 data is stored.
- Writes to addresses that differ are both stored.
- When HAS_ZERO=1, writes to ZERO_REG are discarded, reads of ZERO_REG return 0, and ZERO_REG is never pending.
- Reads are combinational: rd_data and rd_busy reflect the current register state, so the read latency is 0 cycles.
- Every address in 0..DEPTH-1 is readable; there is no default-zero fallthrough except ZERO_REG under HAS_ZERO.
- Pending bits:
  - Set at the clock edge when busy_set_en=1.
  - Cleared at the clock edge by any write (either port) to that address.
  - If a set and a clear hit the same register in one cycle, set wins: the new producer supersedes.
  - Setting an already-pending register leaves it pending.
- dbg_data = register[dbg_addr][DBG_W-1:0], combinational.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: each read port forwards same-cycle write data whenever its address matches an enabled write address (port 1 has priority over port 0, and ZERO_REG is excluded under HAS_ZERO).
  - rd_busy of a forwarded read returns 0 unless busy_set_en targets the same address in that cycle.
  - The forwarding path is purely combinational.
- Undefined: reads return the pre-edge stored value; the written value is visible from the next cycle.
- The debug tap is never bypassed.

Decomposition:
- Package regfile_mp_pkg holds:
  - default constants (RF_DATA_W=64, RF_DEPTH=32, RF_NUM_RD=2);
  - a function that computes the address width;
  - the enum for write-port identifiers (WP_ALU=0, WP_LOAD=1).
- One sub-module, regfile_mp_rdport: a single read port containing the address-decode mux, the zero-register masking and the optional bypass.
  - The top generates NUM_RD instances.
  - Storage, pending bits and write arbitration stay in the top.

Test Plan:
- Reset check: load reg 5 = 64'hDEAD_BEEF, assert reset mid-cycle -> rd_data(port0, addr 5)=0 and rd_busy=0 asynchronously, before the next edge.
- Dual-write conflict: wr0 (addr 3, 64'h1111) and wr1 (addr 3, 64'h2222) in the same cycle -> next cycle, reg 3 reads 64'h2222. Separately, wr0 to addr 4 and wr1 to addr 9 in one cycle -> both stored.
- Zero register (HAS_ZERO=1, DEPTH=32): write 64'hFFFF to addr 31, then busy_set addr 31 -> reads 0 and rd_busy=0. With HAS_ZERO=0, addr 31 reads 64'hFFFF.
- Scoreboard: busy_set addr 7 -> rd_busy=1 the next cycle. Then write addr 7 together with busy_set addr 7 in the same cycle -> remains 1. Then write only -> 0 the following cycle.
- Bypass with REGFILE_MP_BYPASS_EN defined: reg 2 = 0, write 64'hABCD to addr 2 while reading addr 2 -> same-cycle rd_data=64'hABCD. Undefined -> 0 that cycle, 64'hABCD the next.
- Parametric sweep: DATA_W=32, DEPTH=16, NUM_RD=3, DBG_W=8; write i*3 to every reg i -> all three ports and dbg_data (low 8 bits) return the matching values for all 16 addresses.
